csa_quad_feeder: RTL and testbench

// - Upstream/downstream wrapper for the 4-operand 4-bit carry-save adder (csa).
// - Takes a stream of 4-bit operands on a valid/ready input and packs them into groups of four.
// - Drives each group onto the csa a/b/c/d inputs and captures the 6-bit result {cout,sum[4:0]}.
// - Presents the captured result on a valid/ready output.
// - The csa is instantiated outside this block and wired through the csa_* ports.

---
 rtl/csa_quad_feeder.sv | 138 +++++++++++++
 tb/tb_csa_quad_feeder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_quad_feeder.sv
// Packs a 4-bit operand stream into groups of four for an external 4-operand csa and returns
// the sum on a valid/ready output. Define CSA_FEED_ACC_EN to add a running-total accumulator.
module csa_quad_feeder #(
    parameter int unsigned ZERO_PAD = 1,
    parameter int unsigned ACC_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [3:0]       csa_a,
    output logic [3:0]       csa_b,
    output logic [3:0]       csa_c,
    output logic [3:0]       csa_d,
    input  logic [4:0]       csa_sum,
    input  logic             csa_cout,
    output logic [5:0]       out_data,
    output logic [2:0]       out_ops,
    output logic             out_valid,
    input  logic             out_ready
`ifdef CSA_FEED_ACC_EN
    ,
    input  logic             acc_clr,
    output logic [ACC_W-1:0] acc_out
`endif
);

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    localparam bit DROP_PARTIAL = (ZERO_PAD == 0);

    logic [1:0] state_q;
    logic [2:0] idx_q;
    logic [3:0] slot_q [4];
    logic [5:0] out_data_q;
    logic [2:0] out_ops_q;
    logic       out_valid_q;

    logic accept;
    logic close;
    logic drop;

    always_comb begin
        in_ready = (state_q == COLLECT);
        accept   = in_valid && in_ready;
        close    = in_last || (idx_q == 3'd3);
        // A partial group closed by in_last is discarded rather than zero-filled.
        drop     = DROP_PARTIAL && in_last && (idx_q != 3'd3);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= COLLECT;
            idx_q       <= 3'd0;
            out_data_q  <= 6'd0;
            out_ops_q   <= 3'd0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= 4'd0;
            end
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        if (drop) begin
                            idx_q <= 3'd0;
                            for (int i = 0; i < 4; i++) begin
                                slot_q[i] <= 4'd0;
                            end
                        end else begin
                            slot_q[idx_q[1:0]] <= in_data;
                            idx_q              <= idx_q + 3'd1;
                            if (close) begin
                                state_q <= COMPUTE;
                            end
                        end
                    end
                end
                COMPUTE: begin
                    // idx_q already holds the number of operands taken into this group.
                    out_data_q  <= {csa_cout, csa_sum};
                    out_ops_q   <= idx_q;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        idx_q       <= 3'd0;
                        state_q     <= COLLECT;
                        for (int i = 0; i < 4; i++) begin
                            slot_q[i] <= 4'd0;
                        end
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    always_comb begin
        csa_a     = slot_q[0];
        csa_b     = slot_q[1];
        csa_c     = slot_q[2];
        csa_d     = slot_q[3];
        out_data  = out_data_q;
        out_ops   = out_ops_q;
        out_valid = out_valid_q;
    end

    if (ACC_W < 1) begin : g_bad_acc_w
        $error("csa_quad_feeder: ACC_W must be at least 1");
    end

`ifdef CSA_FEED_ACC_EN
    logic [ACC_W-1:0] acc_q;

    // Clear wins over a same-cycle handshake; that group is not added.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (acc_clr) begin
            acc_q <= '0;
        end else if (out_valid_q && out_ready) begin
            acc_q <= acc_q + ACC_W'(out_data_q);
        end
    end

    assign acc_out = acc_q;
`endif

endmodule

// File: tb/tb_csa_quad_feeder.sv
// Directed bench for csa_quad_feeder: behavioural csa per instance, scoreboard of expected
// group results; instance 0 ZERO_PAD=1, 1 ZERO_PAD=0, 2 ACC_W=6.
module tb_csa_quad_feeder;

    logic       clk;
    logic       rst;
    logic [3:0] in_data   [3];
    logic       in_valid  [3];
    logic       in_last   [3];
    logic       in_ready  [3];
    logic [3:0] ca        [3];
    logic [3:0] cb        [3];
    logic [3:0] cc        [3];
    logic [3:0] cd        [3];
    logic [4:0] csum      [3];
    logic       ccout     [3];
    logic [5:0] out_data  [3];
    logic [2:0] out_ops   [3];
    logic       out_valid [3];
    logic       out_ready [3];
`ifdef CSA_FEED_ACC_EN
    logic        acc_clr [3];
    logic [15:0] acc_out0;
    logic [15:0] acc_out1;
    logic [5:0]  acc_out2;
`endif

    int passed = 0;
    int total  = 0;
    logic [8:0] sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_csa
        assign {ccout[g], csum[g]} = 6'(ca[g]) + 6'(cb[g]) + 6'(cc[g]) + 6'(cd[g]);
    end

    csa_quad_feeder #(.ZERO_PAD(1), .ACC_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_last(in_last[0]), .in_ready(in_ready[0]), .csa_a(ca[0]), .csa_b(cb[0]),
        .csa_c(cc[0]), .csa_d(cd[0]), .csa_sum(csum[0]), .csa_cout(ccout[0]),
        .out_data(out_data[0]), .out_ops(out_ops[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0])
`ifdef CSA_FEED_ACC_EN
        , .acc_clr(acc_clr[0]), .acc_out(acc_out0)
`endif
    );

    csa_quad_feeder #(.ZERO_PAD(0), .ACC_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_last(in_last[1]), .in_ready(in_ready[1]), .csa_a(ca[1]), .csa_b(cb[1]),
        .csa_c(cc[1]), .csa_d(cd[1]), .csa_sum(csum[1]), .csa_cout(ccout[1]),
        .out_data(out_data[1]), .out_ops(out_ops[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1])
`ifdef CSA_FEED_ACC_EN
        , .acc_clr(acc_clr[1]), .acc_out(acc_out1)
`endif
    );

    csa_quad_feeder #(.ZERO_PAD(1), .ACC_W(6)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_last(in_last[2]), .in_ready(in_ready[2]), .csa_a(ca[2]), .csa_b(cb[2]),
        .csa_c(cc[2]), .csa_d(cd[2]), .csa_sum(csum[2]), .csa_cout(ccout[2]),
        .out_data(out_data[2]), .out_ops(out_ops[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2])
`ifdef CSA_FEED_ACC_EN
        , .acc_clr(acc_clr[2]), .acc_out(acc_out2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and hold it until accepted (bounded).
    task automatic send(input int sel, input logic [3:0] d, input logic last);
        int n;
        n = 0;
        in_data[sel]  = d;
        in_valid[sel] = 1'b1;
        in_last[sel]  = last;
        while (!in_ready[sel] && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'(in_ready[sel]), 32'd1);
        step();
        in_valid[sel] = 1'b0;
        in_last[sel]  = 1'b0;
    endtask

    task automatic send_group(input int sel, input int n, input logic [3:0] a,
                              input logic [3:0] b, input logic [3:0] c, input logic [3:0] d,
                              input logic last4);
        logic [3:0] v [4];
        int sum;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            sum += int'(v[i]);
            send(sel, v[i], (i == n - 1) && (n < 4 || last4));
        end
        sb.push_back({3'(n), 6'(sum)});
    endtask

    task automatic wait_valid(input int sel);
        int n;
        n = 0;
        while (!out_valid[sel] && n < 20) begin
            step();
            n++;
        end
        check("out_valid_wait", 32'(out_valid[sel]), 32'd1);
    endtask

    task automatic check_result(input int sel);
        logic [8:0] e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("out_data", 32'(out_data[sel]), 32'(e[5:0]));
            check("out_ops", 32'(out_ops[sel]), 32'(e[8:6]));
        end
    endtask

    task automatic ack(input int sel, input logic clr);
        out_ready[sel] = 1'b1;
`ifdef CSA_FEED_ACC_EN
        acc_clr[sel] = clr;
`endif
        step();
        out_ready[sel] = 1'b0;
`ifdef CSA_FEED_ACC_EN
        acc_clr[sel] = 1'b0;
`endif
        if (clr) check("ack_in_ready", 32'(in_ready[sel]), 32'd1);
    endtask

    task automatic take(input int sel);
        wait_valid(sel);
        check_result(sel);
        ack(sel, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data[i] = 4'd0; in_valid[i] = 1'b0; in_last[i] = 1'b0; out_ready[i] = 1'b0;
`ifdef CSA_FEED_ACC_EN
            acc_clr[i] = 1'b0;
`endif
        end
        step();
        step();
        check("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("rst_out_data", 32'(out_data[0]), 32'd0);
        check("rst_out_ops", 32'(out_ops[0]), 32'd0);
        check("rst_csa_a", 32'(ca[0]), 32'd0);
        rst = 1'b0;
        step();
        check("rst_in_ready", 32'(in_ready[0]), 32'd1);

        // Full group of maximum operands; result appears two cycles after the closing accept.
        send_group(0, 4, 4'd15, 4'd15, 4'd15, 4'd15, 1'b0);
        check("lat_compute_valid", 32'(out_valid[0]), 32'd0);
        check("lat_compute_ready", 32'(in_ready[0]), 32'd0);
        step();
        check("lat_hold_valid", 32'(out_valid[0]), 32'd1);
        check_result(0);
        ack(0, 1'b0);
        check("after_ack_valid", 32'(out_valid[0]), 32'd0);

        // Partial group zero-filled.
        send_group(0, 2, 4'd3, 4'd5, 4'd0, 4'd0, 1'b0);
        check("pad_csa_a", 32'(ca[0]), 32'd3);
        check("pad_csa_b", 32'(cb[0]), 32'd5);
        check("pad_csa_c", 32'(cc[0]), 32'd0);
        check("pad_csa_d", 32'(cd[0]), 32'd0);
        take(0);

        // Backpressure: result held stable, a waiting operand is not taken.
        send_group(0, 4, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        wait_valid(0);
        check_result(0);
        in_data[0]  = 4'd9;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_out_data", 32'(out_data[0]), 32'd10);
            check("bp_in_ready", 32'(in_ready[0]), 32'd0);
        end
        out_ready[0] = 1'b1;
        step();
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b0;
        check("bp_release_ready", 32'(in_ready[0]), 32'd1);
        check("bp_no_take", 32'(ca[0]), 32'd0);

        // Reset during COMPUTE discards the group.
        send(0, 4'd1, 1'b0);
        send(0, 4'd2, 1'b0);
        send(0, 4'd3, 1'b0);
        send(0, 4'd4, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(out_valid[0]), 32'd0);
        check("rst_mid_csa", 32'({ca[0], cb[0], cc[0], cd[0]}), 32'd0);
        step();
        rst = 1'b0;
        step();
        step();
        check("rst_mid_no_out", 32'(out_valid[0]), 32'd0);
        send_group(0, 4, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        take(0);

        // ZERO_PAD=0: partial group dropped; in_last on 4th operand is a full group.
        send(1, 4'd7, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("drop_no_valid", 32'(out_valid[1]), 32'd0);
            check("drop_in_ready", 32'(in_ready[1]), 32'd1);
            step();
        end
        check("drop_slot_clear", 32'(ca[1]), 32'd0);
        send_group(1, 4, 4'd1, 4'd1, 4'd1, 4'd1, 1'b0);
        take(1);
        send_group(1, 4, 4'd2, 4'd2, 4'd2, 4'd2, 1'b1);
        take(1);

`ifdef CSA_FEED_ACC_EN
        acc_clr[0] = 1'b1;
        step();
        acc_clr[0] = 1'b0;
        check("acc_clr", 32'(acc_out0), 32'd0);
        send_group(0, 4, 4'd15, 4'd15, 4'd15, 4'd15, 1'b0);
        take(0);
        send_group(0, 4, 4'd15, 4'd15, 4'd15, 4'd15, 1'b0);
        take(0);
        check("acc_120", 32'(acc_out0), 32'd120);
        send_group(0, 4, 4'd15, 4'd15, 4'd15, 4'd15, 1'b0);
        wait_valid(0);
        check_result(0);
        ack(0, 1'b1);
        check("acc_clr_priority", 32'(acc_out0), 32'd0);
        send_group(2, 4, 4'd15, 4'd15, 4'd15, 4'd15, 1'b0);
        take(2);
        send_group(2, 4, 4'd2, 4'd2, 4'd2, 4'd2, 1'b0);
        take(2);
        check("acc_wrap", 32'(acc_out2), 32'd4);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
